// File: rtl/xif_copro_pkg.sv
// Shared coprocessor-interface definitions.
// Contents: copro_op_e operator encoding and the default requester-ID FIFO depth
// used by the EX-stage arbiter.
package xif_copro_pkg;

  typedef enum logic [1:0] {
    CoproAdd = 2'd0,
    CoproSub = 2'd1,
    CoproMul = 2'd2,
    CoproAnd = 2'd3
  } copro_op_e;

  // Default depth of the requester-ID FIFO (power of two, >= 2).
  localparam int unsigned XifMaxOutstanding = 2;

endpackage

// File: rtl/xif_copro_id_fifo.sv
// Requester-ID / tag FIFO for the coprocessor EX arbiter.
// Records which requester issued each in-flight instruction, plus its tag, so results
// can be routed back in issue order.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   push_i                  write push_id_i / push_tag_i (ignored when full)
//   pop_i                   drop the head entry (ignored when empty)
//   full_o, empty_o         occupancy flags
//   head_id_o, head_tag_o   oldest entry
module xif_copro_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ID_W  = 1,
  parameter type         tag_t = logic
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  tag_t            push_tag_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ID_W-1:0] head_id_o,
  output tag_t            head_tag_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = DEPTH[PtrW:0];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic [ID_W-1:0] id_mem [DEPTH];
  tag_t            tag_mem [DEPTH];
  logic            do_push, do_pop;

  assign full_o     = (cnt_q == CntFull);
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign head_id_o  = id_mem[rd_ptr_q];
  assign head_tag_o = tag_mem[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      id_mem[wr_ptr_q]  <= push_id_i;
      tag_mem[wr_ptr_q] <= push_tag_i;
    end
  end

endmodule

// File: rtl/xif_copro_ex_arbiter.sv
// Shares one coprocessor EX stage among NUM_REQ requesters.
// Issue side: round-robin grant, locked while an offered issue is stalled.
// Result side: results return in issue order; a FIFO of requester IDs/tags routes each
// result back to its issuer and cross-checks the returned tag.
// Ports:
//   clk_i, rst_ni                                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o, req_operand_*_i,
//   req_operator_i, req_tag_i                      per-requester issue
//   ex_valid_o/ex_ready_i, ex_operand_*_o,
//   ex_operator_o, ex_tag_o                        issue to EX stage
//   ex_valid_i/ex_ready_o, ex_result_i, ex_tag_i   result from EX stage
//   rsp_valid_o/rsp_ready_i, rsp_result_o,
//   rsp_tag_o                                      per-requester result (payload broadcast)
//   busy_o                                         instructions in flight
//   err_o                                          sticky protocol error
module xif_copro_ex_arbiter
  import xif_copro_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned XLEN            = 64,
  parameter type         tag_t           = logic,
  parameter int unsigned MAX_OUTSTANDING = XifMaxOutstanding
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_operand_a_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_operand_b_i,
  input  copro_op_e [NUM_REQ-1:0]       req_operator_i,
  input  tag_t [NUM_REQ-1:0]            req_tag_i,
  output logic                          ex_valid_o,
  input  logic                          ex_ready_i,
  output logic [XLEN-1:0]               ex_operand_a_o,
  output logic [XLEN-1:0]               ex_operand_b_o,
  output copro_op_e                     ex_operator_o,
  output tag_t                          ex_tag_o,
  input  logic                          ex_valid_i,
  output logic                          ex_ready_o,
  input  logic [XLEN-1:0]               ex_result_i,
  input  tag_t                          ex_tag_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [XLEN-1:0]               rsp_result_o,
  output tag_t                          rsp_tag_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] grant, cand, head_idx;
  logic            gnt_valid;
  logic            fifo_full, fifo_empty, push, pop;
  tag_t            head_tag;

  // Round-robin search starting at rr_ptr_q, unless a stalled offer holds the grant.
  always_comb begin
    grant     = lock_idx_q;
    gnt_valid = lock_q;
    cand      = '0;
    if (!lock_q) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!gnt_valid && req_valid_i[cand]) begin
          grant     = cand;
          gnt_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ex_valid_o     = gnt_valid & req_valid_i[grant] & ~fifo_full;
    ex_operand_a_o = '0;
    ex_operand_b_o = '0;
    ex_operator_o  = copro_op_e'('0);
    ex_tag_o       = '0;
    req_ready_o    = '0;
    if (gnt_valid) begin
      ex_operand_a_o = req_operand_a_i[grant];
      ex_operand_b_o = req_operand_b_i[grant];
      ex_operator_o  = req_operator_i[grant];
      ex_tag_o       = req_tag_i[grant];
      req_ready_o[grant] = ex_ready_i & ~fifo_full;
    end
    push = ex_valid_o & ex_ready_i;

    rr_ptr_d   = rr_ptr_q;
    if (push) rr_ptr_d = (grant == LastIdx) ? '0 : grant + 1'b1;
    lock_d     = ex_valid_o & ~ex_ready_i;
    lock_idx_d = grant;
  end

  // Result routing: head of the ID FIFO owns the current result beat.
  always_comb begin
    rsp_valid_o = '0;
    if (!fifo_empty) rsp_valid_o[head_idx] = ex_valid_i;
    ex_ready_o   = ~fifo_empty & rsp_ready_i[head_idx];
    pop          = ex_valid_i & ex_ready_o;
    rsp_result_o = ex_result_i;
    rsp_tag_o    = ex_tag_i;
    err_d        = err_q | (ex_valid_i & fifo_empty) | (pop & (ex_tag_i != head_tag));
  end

  assign busy_o = ~fifo_empty;
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  xif_copro_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (IdxW),
    .tag_t (tag_t)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_id_i  (grant),
    .push_tag_i (ex_tag_o),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_id_o  (head_idx),
    .head_tag_o (head_tag)
  );

endmodule

// File: tb/tb_xif_copro_ex_arbiter.sv
module tb_xif_copro_ex_arbiter;
  import xif_copro_pkg::*;

  typedef logic [3:0] tag_t;
  typedef struct {
    int   idx;
    tag_t tag;
  } exp_t;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [1:0]            req_valid_i, req_ready_o;
  logic [1:0][63:0]      req_operand_a_i, req_operand_b_i;
  copro_op_e [1:0]       req_operator_i;
  tag_t [1:0]            req_tag_i;
  logic                  ex_valid_o, ex_ready_i;
  logic [63:0]           ex_operand_a_o, ex_operand_b_o;
  copro_op_e             ex_operator_o;
  tag_t                  ex_tag_o;
  logic                  ex_valid_i, ex_ready_o;
  logic [63:0]           ex_result_i;
  tag_t                  ex_tag_i;
  logic [1:0]            rsp_valid_o, rsp_ready_i;
  logic [63:0]           rsp_result_o;
  tag_t                  rsp_tag_o;
  logic                  busy_o, err_o;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  tag_t ex_pipe[$];

  always #5 clk_i = ~clk_i;

  xif_copro_ex_arbiter #(
    .NUM_REQ         (2),
    .XLEN            (64),
    .tag_t           (tag_t),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_operand_a_i (req_operand_a_i),
    .req_operand_b_i (req_operand_b_i),
    .req_operator_i  (req_operator_i),
    .req_tag_i       (req_tag_i),
    .ex_valid_o      (ex_valid_o),
    .ex_ready_i      (ex_ready_i),
    .ex_operand_a_o  (ex_operand_a_o),
    .ex_operand_b_o  (ex_operand_b_o),
    .ex_operator_o   (ex_operator_o),
    .ex_tag_o        (ex_tag_o),
    .ex_valid_i      (ex_valid_i),
    .ex_ready_o      (ex_ready_o),
    .ex_result_i     (ex_result_i),
    .ex_tag_i        (ex_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_result_o    (rsp_result_o),
    .rsp_tag_o       (rsp_tag_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] opa(input int i, input tag_t t);
    return 64'hA000_0000_0000_0000 | (64'(i) << 8) | 64'(t);
  endfunction

  function automatic logic [63:0] onehot(input int i);
    return 64'd1 << i;
  endfunction

  task automatic idle_inputs();
    req_valid_i = '0;
    ex_ready_i  = 1'b0;
    rsp_ready_i = '0;
    ex_valid_i  = 1'b0;
    ex_tag_i    = '0;
    ex_result_i = '0;
    for (int i = 0; i < 2; i++) begin
      req_tag_i[i]       = '0;
      req_operand_a_i[i] = '0;
      req_operand_b_i[i] = '0;
      req_operator_i[i]  = CoproAdd;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    idle_inputs();
    sb.delete();
    ex_pipe.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One cycle: drive requests, let the EX model return its oldest result, check both sides.
  // exp_g is the requester expected to be offered to EX this cycle, -1 for none.
  task automatic tick(input logic [1:0] rv, input logic er, input logic [1:0] rr,
                      input tag_t t0, input tag_t t1, input int exp_g);
    exp_t e;
    @(negedge clk_i);
    req_valid_i  = rv;
    ex_ready_i   = er;
    rsp_ready_i  = rr;
    req_tag_i[0] = t0;
    req_tag_i[1] = t1;
    for (int i = 0; i < 2; i++) begin
      req_operand_a_i[i] = opa(i, req_tag_i[i]);
      req_operand_b_i[i] = ~opa(i, req_tag_i[i]);
      req_operator_i[i]  = (i == 0) ? CoproAdd : CoproMul;
    end
    ex_valid_i  = (ex_pipe.size() != 0);
    ex_tag_i    = ex_valid_i ? ex_pipe[0] : '0;
    ex_result_i = 64'h5EED_0000_0000_0000 | 64'(ex_tag_i);
    #1;
    if (ex_valid_i) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 64'(sb.size()), 64'd1);
      end else begin
        e = sb[0];
        check("rsp_valid", 64'(rsp_valid_o), onehot(e.idx));
        check("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
        check("rsp_result", rsp_result_o, ex_result_i);
        check("ex_ready_o", 64'(ex_ready_o), 64'(rr[e.idx]));
        if (rr[e.idx]) begin
          void'(sb.pop_front());
          void'(ex_pipe.pop_front());
        end
      end
    end else begin
      check("rsp_idle", 64'(rsp_valid_o), 64'd0);
    end
    if (exp_g >= 0) begin
      check("ex_valid_o", 64'(ex_valid_o), 64'd1);
      check("req_ready", 64'(req_ready_o), er ? onehot(exp_g) : 64'd0);
      check("ex_tag_o", 64'(ex_tag_o), 64'(req_tag_i[exp_g]));
      check("ex_opa", ex_operand_a_o, opa(exp_g, req_tag_i[exp_g]));
      check("ex_opb", ex_operand_b_o, ~opa(exp_g, req_tag_i[exp_g]));
      check("ex_op", 64'(ex_operator_o), (exp_g == 0) ? 64'(CoproAdd) : 64'(CoproMul));
      if (er) begin
        sb.push_back('{idx: exp_g, tag: req_tag_i[exp_g]});
        ex_pipe.push_back(ex_tag_o);
      end
    end else begin
      check("ex_valid_blk", 64'(ex_valid_o), 64'd0);
      check("req_ready_blk", 64'(req_ready_o), 64'd0);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    #1;
    // Reset state.
    check("rst_ex_valid", 64'(ex_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_ex_ready", 64'(ex_ready_o), 64'd0);

    // Both requesters busy, EX always ready: grants alternate.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick(2'b11, 1'b1, 2'b11, tag_t'(2 * c), tag_t'(2 * c + 1), c % 2);
    end
    tick(2'b00, 1'b1, 2'b11, 4'h0, 4'h0, -1);
    tick(2'b00, 1'b1, 2'b11, 4'h0, 4'h0, -1);
    check("alt_drained", 64'(busy_o), 64'd0);

    // Stalled offer from requester 1 keeps the grant even though 0 has priority.
    do_reset();
    tick(2'b10, 1'b0, 2'b11, 4'h1, 4'h2, 1);
    tick(2'b10, 1'b0, 2'b11, 4'h1, 4'h2, 1);
    tick(2'b11, 1'b0, 2'b11, 4'h1, 4'h2, 1);
    tick(2'b11, 1'b1, 2'b11, 4'h1, 4'h2, 1);
    tick(2'b11, 1'b1, 2'b11, 4'h3, 4'h4, 0);
    tick(2'b00, 1'b1, 2'b11, 4'h0, 4'h0, -1);
    tick(2'b00, 1'b1, 2'b11, 4'h0, 4'h0, -1);

    // Fill the FIFO with tags 5,6, block, then drain; pop at full frees a slot next cycle.
    do_reset();
    tick(2'b01, 1'b1, 2'b00, 4'h5, 4'h0, 0);
    tick(2'b01, 1'b1, 2'b00, 4'h6, 4'h0, 0);
    tick(2'b01, 1'b1, 2'b00, 4'h7, 4'h0, -1);
    check("full_busy", 64'(busy_o), 64'd1);
    tick(2'b01, 1'b1, 2'b11, 4'h7, 4'h0, -1);
    tick(2'b01, 1'b1, 2'b11, 4'h7, 4'h0, 0);
    tick(2'b00, 1'b1, 2'b11, 4'h0, 4'h0, -1);
    tick(2'b00, 1'b1, 2'b11, 4'h0, 4'h0, -1);
    check("full_drained", 64'(busy_o), 64'd0);
    check("full_no_err", 64'(err_o), 64'd0);

    // Result beat with nothing outstanding: not acknowledged, sticky error.
    do_reset();
    @(negedge clk_i);
    ex_valid_i = 1'b1;
    #1;
    check("spur_ex_ready", 64'(ex_ready_o), 64'd0);
    check("spur_rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(negedge clk_i);
    ex_valid_i = 1'b0;
    #1;
    check("spur_err_set", 64'(err_o), 64'd1);
    repeat (2) @(negedge clk_i);
    check("spur_err_held", 64'(err_o), 64'd1);

    // Returned tag differs from the recorded one.
    do_reset();
    check("err_cleared", 64'(err_o), 64'd0);
    tick(2'b01, 1'b1, 2'b00, 4'h3, 4'h0, 0);
    @(negedge clk_i);
    req_valid_i = '0;
    ex_valid_i  = 1'b1;
    ex_tag_i    = 4'h4;
    rsp_ready_i = 2'b01;
    #1;
    check("tagmm_ex_ready", 64'(ex_ready_o), 64'd1);
    @(negedge clk_i);
    ex_valid_i = 1'b0;
    #1;
    check("tagmm_err", 64'(err_o), 64'd1);
    check("tagmm_popped", 64'(busy_o), 64'd0);

    // Asynchronous reset with one instruction outstanding.
    do_reset();
    tick(2'b01, 1'b1, 2'b00, 4'h9, 4'h0, 0);
    @(negedge clk_i);
    req_valid_i = '0;
    ex_valid_i  = 1'b1;
    ex_tag_i    = 4'h9;
    rsp_ready_i = 2'b00;
    #1;
    check("flight_rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("flight_busy", 64'(busy_o), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("arst_ex_ready", 64'(ex_ready_o), 64'd0);
    @(negedge clk_i);
    idle_inputs();
    sb.delete();
    ex_pipe.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(2'b11, 1'b1, 2'b11, 4'hA, 4'hB, 0);
    tick(2'b00, 1'b1, 2'b11, 4'h0, 4'h0, -1);
    check("post_rst_err", 64'(err_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xif_copro_ex_arbiter.md
XIF_COPRO_EX_ARBITER -- requirements
Module: xif_copro_ex_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one EX stage (2..8).
REQ-002 SHALL have parameter XLEN, default 64, operand/result width.
REQ-003 SHALL have parameter tag_t, default logic, instruction tag type.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, depth of the requester-ID FIFO (power of two, >=2).
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  NUM_REQ  per-requester issue valid.
REQ-008 req_ready_o  out  NUM_REQ  per-requester issue ready.
REQ-009 req_operand_a_i / req_operand_b_i  in  NUM_REQ x XLEN  per-requester operands.
REQ-010 req_operator_i  in  NUM_REQ x copro_op_e  per-requester operator.
REQ-011 req_tag_i  in  NUM_REQ x tag_t  per-requester tag.
REQ-012 ex_valid_o / ex_ready_i  out/in  1  issue handshake to EX stage.
REQ-013 ex_operand_a_o / ex_operand_b_o / ex_operator_o / ex_tag_o  out  XLEN/XLEN/copro_op_e/tag_t  muxed issue payload.
REQ-014 ex_valid_i / ex_ready_o  in/out  1  result handshake from EX stage.
REQ-015 ex_result_i / ex_tag_i  in  XLEN/tag_t  EX result payload.
REQ-016 rsp_valid_o / rsp_ready_i  out/in  NUM_REQ  per-requester result handshake.
REQ-017 rsp_result_o / rsp_tag_o  out  XLEN/tag_t  result payload, broadcast to all requesters.
REQ-018 busy_o  out  1  high while the ID FIFO is non-empty.
REQ-019 err_o  out  1  sticky protocol-error flag.

Function
REQ-020 Grant SHALL be round-robin: highest priority goes to the index after the last requester whose issue handshake completed; after reset, index 0 has highest priority.
REQ-021 Once ex_valid_o is high for requester i without ex_ready_i, grant SHALL stay locked on i until the handshake completes, regardless of other requests.
REQ-022 ex_valid_o SHALL be req_valid_i[grant] & ~fifo_full; payload SHALL be the granted requester's inputs, and '0 when no requester is granted.
REQ-023 req_ready_o[i] SHALL be ex_ready_i & ~fifo_full & (grant==i); all other bits SHALL be 0.
REQ-024 Each issue handshake SHALL push the granted index into the ID FIFO in the same cycle; the round-robin pointer SHALL update on the next edge.
REQ-025 rsp_valid_o[head] SHALL be ex_valid_i & ~fifo_empty; all other rsp_valid_o bits SHALL be 0.
REQ-026 ex_ready_o SHALL be rsp_ready_i[head] & ~fifo_empty; result/tag SHALL pass through combinationally, with zero latency.
REQ-027 Each result handshake SHALL pop the FIFO head.
REQ-028 Simultaneous push and pop SHALL leave the occupancy unchanged; both pointers SHALL advance, modulo MAX_OUTSTANDING.
REQ-029 At full, no issue SHALL be accepted (ex_valid_o=0); a pop in that cycle SHALL free a slot starting the next cycle, with no same-cycle bypass.
REQ-030 ex_valid_i while the FIFO is empty SHALL set err_o, which stays set until reset; the beat SHALL NOT be acknowledged (ex_ready_o=0).
REQ-031 ex_tag_i differing from the tag recorded alongside the head index at push SHALL set err_o during a result handshake.

Reset
REQ-032 On reset, the FIFO SHALL be empty, pointers 0, round-robin pointer 0, lock cleared, err_o=0, busy_o=0, ex_valid_o=0, all rsp_valid_o=0, and all req_ready_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding IDs immediately (asynchronously); EX-side state is the EX stage's own responsibility.

Structure
REQ-034 copro_op_e SHALL come from the shared xif_copro_pkg; MAX_OUTSTANDING's default SHALL be added there as a localparam.
REQ-035 The requester-ID/tag FIFO SHALL be the sub-module xif_copro_id_fifo (push/pop/full/empty/head); the arbitration logic stays inline.

Verification
REQ-036 Requesters 0 and 1 both valid continuously, EX always ready with 0-cycle result -> grants alternate 0,1,0,1; each rsp_valid_o matches the issuing index.
REQ-037 Requester 1 valid, ex_ready_i low for 3 cycles, then requester 0 raises valid -> grant stays 1 until accepted; 0 is granted next.
REQ-038 Two issues from requester 0 (tags 5 and 6), rsp_ready_i low -> third issue blocked (ex_valid_o=0); raise rsp_ready_i -> results return in order 5,6 and the third issue is accepted the cycle after the first pop.
REQ-039 Full FIFO with simultaneous issue attempt and result pop -> no issue that cycle; occupancy drops 2->1, then issue is accepted next cycle.
REQ-040 ex_valid_i=1 pulsed with the FIFO empty -> err_o=1 and held; ex_ready_o=0.
REQ-041 rst_ni low mid-flight with 1 outstanding -> busy_o=0, rsp_valid_o=0 asynchronously; first post-reset grant goes to index 0.
